// File: rtl/ethtx_pkg.sv
// ethtx_pkg: shared state encodings and default constants
// for the Ethernet transmit sequencer slice.
package ethtx_pkg;

    localparam int IPG_DEF     = 24;
    localparam int MIN_LEN_DEF = 60;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_DATA = 3'd2,
        ST_GAP  = 3'd3
`ifdef ETHTX_PAD_EN
        ,
        ST_PAD  = 3'd4
`endif
    } state_e;

endpackage

// File: rtl/ethtx_sequencer_if.sv
// ethtx_sequencer_if: control, buffer-read and nibble-stream
// signals between a frame source and the transmit sequencer.
interface ethtx_sequencer_if #(
    parameter int AW = 11
);
    import ethtx_pkg::*;

    logic          i_ce;
    logic          i_cmd;
    logic [AW:0]   i_len;
    logic          i_abort;
    logic [AW-1:0] o_rd_addr;
    logic [7:0]    i_rd_data;
    logic          o_v;
    logic [3:0]    o_d;
    logic          o_cancel;
    logic          o_busy;
    logic          o_done;

    modport slave (
        input  i_ce,
        input  i_cmd,
        input  i_len,
        input  i_abort,
        input  i_rd_data,
        output o_rd_addr,
        output o_v,
        output o_d,
        output o_cancel,
        output o_busy,
        output o_done
    );

    modport master (
        output i_ce,
        output i_cmd,
        output i_len,
        output i_abort,
        output i_rd_data,
        input  o_rd_addr,
        input  o_v,
        input  o_d,
        input  o_cancel,
        input  o_busy,
        input  o_done
    );

endinterface

// File: rtl/ethtx_nibbler.sv
// ethtx_nibbler: byte register, low/high nibble select and
// nibble counter for the transmit sequencer.
module ethtx_nibbler
    import ethtx_pkg::*;
#(
    parameter int AW = 11
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic          i_start,
    input  logic          i_load,
    input  logic          i_step,
`ifdef ETHTX_PAD_EN
    input  logic          i_pad,
`endif
    input  logic [7:0]    i_rd_data,
    output logic [3:0]    o_nib,
    output logic          o_hi,
    output logic [AW+1:0] o_cnt
);

    logic [7:0]    byte_q, byte_d;
    logic          hi_q, hi_d;
    logic [AW+1:0] cnt_q, cnt_d;

    always_comb begin
        byte_d = byte_q;
        hi_d   = hi_q;
        cnt_d  = cnt_q;
        if (i_start) begin
            hi_d  = 1'b0;
            cnt_d = '0;
        end
        if (i_load) begin
            byte_d = i_rd_data;
        end
        if (i_step) begin
            cnt_d = cnt_q + 1'b1;
            hi_d  = ~hi_q;
            // next byte is already waiting on the read port
            if (hi_q) begin
                byte_d = i_rd_data;
            end
        end
`ifdef ETHTX_PAD_EN
        if (i_pad) begin
            cnt_d = cnt_q + 1'b1;
        end
`endif
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            byte_q <= '0;
            hi_q   <= 1'b0;
            cnt_q  <= '0;
        end else begin
            byte_q <= byte_d;
            hi_q   <= hi_d;
            cnt_q  <= cnt_d;
        end
    end

    assign o_nib = hi_q ? byte_q[7:4] : byte_q[3:0];
    assign o_hi  = hi_q;
    assign o_cnt = cnt_q;

endmodule

// File: rtl/ethtx_sequencer.sv
// ethtx_sequencer: frame sequencer feeding a preamble inserter.
// Define ETHTX_PAD_EN to pad short frames to MIN_LEN bytes.
module ethtx_sequencer
    import ethtx_pkg::*;
#(
    parameter int AW          = 11,
    parameter int IPG_NIBBLES = IPG_DEF,
    parameter int MIN_LEN     = MIN_LEN_DEF
) (
    input  logic i_clk,
    input  logic i_reset,
    ethtx_sequencer_if.slave bus
);

    localparam int GW = $clog2(IPG_NIBBLES + 1);

    state_e        state_q, state_d;
    logic [AW:0]   len_q, len_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [GW-1:0] gap_q, gap_d;
    logic          pend_q, pend_d;
    logic          v_q, v_d;
    logic [3:0]    d_q, d_d;
    logic          cancel_q, cancel_d;
    logic          done_q, done_d;

    logic          nb_start, nb_load, nb_step;
    logic [3:0]    nb_nib;
    logic          nb_hi;
    logic [AW+1:0] nb_cnt;

    logic          abort_req;
    logic          data_last;
    logic          gap_last;
    logic          in_frame;
    logic [AW+1:0] last_nib;

    assign last_nib  = {len_q, 1'b0} - 1'b1;
    assign data_last = (nb_cnt == last_nib);
    assign gap_last  = (gap_q == GW'(IPG_NIBBLES - 1));
    assign abort_req = bus.i_abort | pend_q;

`ifdef ETHTX_PAD_EN
    logic nb_pad;
    logic need_pad;
    logic pad_last;

    assign need_pad = (len_q < (AW+1)'(MIN_LEN));
    assign pad_last = (nb_cnt == (AW+2)'(2 * MIN_LEN - 1));
    assign in_frame = (state_q == ST_LOAD) ||
                      (state_q == ST_DATA) ||
                      (state_q == ST_PAD);
`else
    assign in_frame = (state_q == ST_LOAD) ||
                      (state_q == ST_DATA);
`endif

    ethtx_nibbler #(
        .AW (AW)
    ) u_nibbler (
        .i_clk     (i_clk),
        .i_reset   (i_reset),
        .i_start   (nb_start),
        .i_load    (nb_load),
        .i_step    (nb_step),
`ifdef ETHTX_PAD_EN
        .i_pad     (nb_pad),
`endif
        .i_rd_data (bus.i_rd_data),
        .o_nib     (nb_nib),
        .o_hi      (nb_hi),
        .o_cnt     (nb_cnt)
    );

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q  <= ST_IDLE;
            len_q    <= '0;
            addr_q   <= '0;
            gap_q    <= '0;
            pend_q   <= 1'b0;
            v_q      <= 1'b0;
            d_q      <= '0;
            cancel_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            len_q    <= len_d;
            addr_q   <= addr_d;
            gap_q    <= gap_d;
            pend_q   <= pend_d;
            v_q      <= v_d;
            d_q      <= d_d;
            cancel_q <= cancel_d;
            done_q   <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (bus.i_cmd && (bus.i_len != '0)) begin
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (bus.i_ce && abort_req) begin
                    state_d = ST_GAP;
                end else begin
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (bus.i_ce) begin
                    if (abort_req) begin
                        state_d = ST_GAP;
`ifdef ETHTX_PAD_EN
                    end else if (data_last && need_pad) begin
                        state_d = ST_PAD;
`endif
                    end else if (data_last) begin
                        state_d = ST_GAP;
                    end
                end
            end
`ifdef ETHTX_PAD_EN
            ST_PAD: begin
                if (bus.i_ce && (abort_req || pad_last)) begin
                    state_d = ST_GAP;
                end
            end
`endif
            ST_GAP: begin
                if (bus.i_ce && gap_last) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        len_d    = len_q;
        addr_d   = addr_q;
        gap_d    = gap_q;
        pend_d   = pend_q;
        v_d      = v_q;
        d_d      = d_q;
        cancel_d = cancel_q;
        done_d   = 1'b0;
        nb_start = 1'b0;
        nb_load  = 1'b0;
        nb_step  = 1'b0;
`ifdef ETHTX_PAD_EN
        nb_pad   = 1'b0;
`endif
        if (state_q != ST_GAP) begin
            gap_d = '0;
        end
        unique case (state_q)
            ST_IDLE: begin
                if (bus.i_cmd && (bus.i_len != '0)) begin
                    len_d    = bus.i_len;
                    addr_d   = '0;
                    pend_d   = 1'b0;
                    nb_start = 1'b1;
                end else if (bus.i_cmd) begin
                    done_d = 1'b1;
                end
            end
            ST_LOAD: begin
                nb_load = 1'b1;
                addr_d  = addr_q + 1'b1;
            end
            ST_DATA: begin
                if (bus.i_ce && !abort_req) begin
                    v_d     = 1'b1;
                    d_d     = nb_nib;
                    nb_step = 1'b1;
                    if (nb_hi) begin
                        addr_d = addr_q + 1'b1;
                    end
                end
            end
`ifdef ETHTX_PAD_EN
            ST_PAD: begin
                if (bus.i_ce && !abort_req) begin
                    v_d    = 1'b1;
                    d_d    = '0;
                    nb_pad = 1'b1;
                end
            end
`endif
            ST_GAP: begin
                if (bus.i_ce) begin
                    v_d      = 1'b0;
                    d_d      = '0;
                    cancel_d = 1'b0;
                    gap_d    = gap_q + 1'b1;
                    // park on byte 0 so the next LOAD finds it ready
                    if (gap_last) begin
                        done_d = 1'b1;
                        addr_d = '0;
                    end
                end
            end
            default: ;
        endcase
        if (in_frame) begin
            if (bus.i_ce && abort_req) begin
                v_d      = 1'b0;
                d_d      = '0;
                cancel_d = 1'b1;
                pend_d   = 1'b0;
            end else if (bus.i_abort) begin
                pend_d = 1'b1;
            end
        end
    end

    assign bus.o_rd_addr = addr_q;
    assign bus.o_v       = v_q;
    assign bus.o_d       = d_q;
    assign bus.o_cancel  = cancel_q;
    assign bus.o_done    = done_q;
    assign bus.o_busy    = (state_q != ST_IDLE);

endmodule

// File: tb/tb_ethtx_sequencer.sv
// tb_ethtx_sequencer: table-driven frame vectors plus directed
// reset, zero-length and busy-command sequences.
module tb_ethtx_sequencer;

    localparam int AW = 11;

    typedef struct {
        int len;
        int per;
        int abort_at;
        int bcmd_at;
        int nibs;
        int cancels;
        int gap;
    } vec_t;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    int   cyc;
    int   ce_per;

    logic [7:0] mem [0:(1<<AW)-1];
    logic [3:0] nib_q [$];
    int   cancel_cnt, cancel_cyc;
    int   done_cnt, done_cyc;
    int   last_v_cyc, stab_err;
    logic pv, pc;
    logic [3:0] pd;

    ethtx_sequencer_if #(.AW(AW)) bus ();

    ethtx_sequencer #(
        .AW (AW)
    ) dut (
        .i_clk   (clk),
        .i_reset (rst),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_ff @(posedge clk) begin
        bus.i_rd_data <= mem[bus.o_rd_addr];
    end

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d",
                     name, act, exp);
        end
    endtask

    function automatic logic [3:0] exp_nib(int k, int len);
        logic [7:0] b;
        if (k >= 2 * len) return 4'h0;
        b = mem[k/2];
        return (k % 2 == 1) ? b[7:4] : b[3:0];
    endfunction

    task automatic clr_obs();
        nib_q.delete();
        cancel_cnt = 0;
        cancel_cyc = -1;
        done_cnt   = 0;
        done_cyc   = -1;
        last_v_cyc = -1;
        stab_err   = 0;
    endtask

    task automatic clk_step();
        logic ce_at, rst_at;
        ce_at  = bus.i_ce;
        rst_at = rst;
        @(posedge clk);
        #1;
        cyc++;
        if (!ce_at && !rst_at &&
            (bus.o_v !== pv || bus.o_d !== pd ||
             bus.o_cancel !== pc)) stab_err++;
        pv = bus.o_v;
        pd = bus.o_d;
        pc = bus.o_cancel;
        if (ce_at && bus.o_v) nib_q.push_back(bus.o_d);
        if (bus.o_v) last_v_cyc = cyc;
        if (bus.o_cancel) begin
            if (cancel_cyc < 0) cancel_cyc = cyc;
            if (ce_at) cancel_cnt++;
        end
        if (bus.o_done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        bus.i_ce = ((cyc % ce_per) == 0);
    endtask

    task automatic run_frame(vec_t v);
        int  mism;
        int  meas;
        bit  ab_done, bc_done;
        ce_per  = v.per;
        ab_done = 0;
        bc_done = 0;
        clr_obs();
        bus.i_cmd = 1'b1;
        bus.i_len = (AW+1)'(v.len);
        clk_step();
        bus.i_cmd = 1'b0;
        chk("busy_start", int'(bus.o_busy), 1);
        for (int n = 0; n < 4000 && done_cnt == 0; n++) begin
            bus.i_abort = 1'b0;
            bus.i_cmd   = 1'b0;
            if (v.abort_at >= 0 && !ab_done &&
                nib_q.size() == v.abort_at) begin
                bus.i_abort = 1'b1;
                ab_done = 1;
            end
            if (v.bcmd_at >= 0 && !bc_done &&
                nib_q.size() == v.bcmd_at) begin
                bus.i_cmd = 1'b1;
                bus.i_len = (AW+1)'(5);
                bc_done = 1;
            end
            clk_step();
        end
        bus.i_abort = 1'b0;
        bus.i_cmd   = 1'b0;
        chk("done_seen", done_cnt, 1);
        chk("nibbles", nib_q.size(), v.nibs);
        mism = 0;
        foreach (nib_q[k]) begin
            if (nib_q[k] !== exp_nib(k, v.len)) mism++;
        end
        chk("stream", mism, 0);
        chk("cancels", cancel_cnt, v.cancels);
        if (v.cancels > 0) meas = done_cyc - cancel_cyc;
        else meas = done_cyc - last_v_cyc;
        chk("gap", meas, v.gap);
        clk_step();
        chk("done_pulse", int'(bus.o_done), 0);
        chk("idle_busy", int'(bus.o_busy), 0);
        repeat (4) clk_step();
        chk("stay_idle", int'(bus.o_busy), 0);
        chk("ce_stable", stab_err, 0);
    endtask

    vec_t tbl [10];

    initial begin
        checks = 0;
        errors = 0;
        cyc    = 0;
        ce_per = 1;
        pv = 1'b0;
        pc = 1'b0;
        pd = 4'h0;
        for (int i = 0; i < (1 << AW); i++) mem[i] = 8'(i);
        tbl[0] = '{16, 1, -1, -1, 32, 0, 24};
`ifdef ETHTX_PAD_EN
        tbl[1] = '{10, 1, -1, -1, 120, 0, 24};
        tbl[9] = '{1, 1, -1, -1, 120, 0, 24};
`else
        tbl[1] = '{10, 1, -1, -1, 20, 0, 24};
        tbl[9] = '{1, 1, -1, -1, 2, 0, 24};
`endif
        tbl[2] = '{4, 4, -1, -1, 8, 0, 93};
        tbl[3] = '{4, 1, -1, -1, 8, 0, 24};
        tbl[4] = '{64, 1, 7, -1, 7, 1, 24};
        tbl[5] = '{8, 2, 3, -1, 3, 1, 48};
        tbl[6] = '{16, 1, -1, 5, 32, 0, 24};
        tbl[7] = '{60, 1, -1, -1, 120, 0, 24};
        tbl[8] = '{61, 1, -1, -1, 122, 0, 24};

        rst = 1'b1;
        bus.i_ce    = 1'b0;
        bus.i_cmd   = 1'b0;
        bus.i_len   = '0;
        bus.i_abort = 1'b0;
        clr_obs();
        repeat (3) clk_step();
        chk("rst_v", int'(bus.o_v), 0);
        chk("rst_d", int'(bus.o_d), 0);
        chk("rst_cancel", int'(bus.o_cancel), 0);
        chk("rst_done", int'(bus.o_done), 0);
        chk("rst_busy", int'(bus.o_busy), 0);
        chk("rst_addr", int'(bus.o_rd_addr), 0);
        rst = 1'b0;
        clk_step();

        bus.i_cmd = 1'b1;
        bus.i_len = '0;
        clk_step();
        bus.i_cmd = 1'b0;
        chk("len0_done", int'(bus.o_done), 1);
        chk("len0_busy", int'(bus.o_busy), 0);
        clk_step();
        chk("len0_pulse", int'(bus.o_done), 0);
        chk("len0_idle", int'(bus.o_busy), 0);

        for (int i = 0; i < 10; i++) run_frame(tbl[i]);

        ce_per = 1;
        clr_obs();
        bus.i_cmd = 1'b1;
        bus.i_len = (AW+1)'(32);
        clk_step();
        bus.i_cmd = 1'b0;
        for (int n = 0; n < 200 && nib_q.size() < 10; n++) clk_step();
        chk("mid_nibs", nib_q.size(), 10);
        rst = 1'b1;
        clk_step();
        rst = 1'b0;
        chk("mrst_v", int'(bus.o_v), 0);
        chk("mrst_d", int'(bus.o_d), 0);
        chk("mrst_cancel", int'(bus.o_cancel), 0);
        chk("mrst_done", int'(bus.o_done), 0);
        chk("mrst_busy", int'(bus.o_busy), 0);
        chk("mrst_addr", int'(bus.o_rd_addr), 0);
        repeat (30) clk_step();
        chk("mrst_no_cancel", int'(cancel_cyc >= 0), 0);
        chk("mrst_no_done", done_cnt, 0);
        run_frame(tbl[3]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ethtx_sequencer.md
ETHTX_SEQUENCER -- requirements
Module: ethtx_sequencer

Interface
REQ-001 Parameter AW, default 11: packet-buffer byte address width.
REQ-002 Parameter IPG_NIBBLES, default 24: inter-packet gap in nibble times (96 bit times).
REQ-003 Parameter MIN_LEN, default 60: minimum frame length in bytes, applied when padding is compiled in.
REQ-004 i_clk in 1: single clock; all logic on rising edge.
REQ-005 i_reset in 1: reset, synchronous and active-high.
REQ-006 i_ce in 1: nibble-rate clock enable; may be high every clock.
REQ-007 i_cmd in 1: start-frame strobe.
REQ-008 i_len in AW+1: frame length in bytes, sampled with i_cmd.
REQ-009 i_abort in 1: abort the frame in progress.
REQ-010 o_rd_addr out AW: packet-buffer byte address.
REQ-011 i_rd_data in 8: buffer byte; valid one i_clk after o_rd_addr.
REQ-012 o_v out 1 / o_d out 4: nibble stream to the preamble inserter, low nibble of each byte first.
REQ-013 o_cancel out 1: cancel strobe to the preamble inserter.
REQ-014 o_busy out 1: high in any state other than IDLE.
REQ-015 o_done out 1: one-clock pulse on return to IDLE.

Function
REQ-016 The block SHALL implement the states IDLE, LOAD, DATA, PAD, GAP.
REQ-017 IDLE: when i_cmd=1 and i_len!=0, the block SHALL latch i_len, set o_rd_addr=0 and enter LOAD; when i_cmd=1 and i_len=0, it SHALL pulse o_done on the next clock and remain in IDLE.
REQ-018 i_cmd SHALL be ignored while o_busy=1.
REQ-019 LOAD SHALL last exactly one clock, capture byte 0 into the byte register, advance o_rd_addr, and enter DATA.
REQ-020 DATA, on each i_ce: emit o_v=1 with the low nibble, then on the next i_ce the high nibble.
REQ-021 On emitting a high nibble, the block SHALL load the byte register from i_rd_data and advance o_rd_addr.
REQ-022 The byte path SHALL keep emission gap-free with i_ce high every clock.
REQ-023 After the high nibble of byte len-1, the block SHALL go to PAD if padding is enabled and len<MIN_LEN, else to GAP.
REQ-024 PAD SHALL emit zero nibbles (o_v=1, o_d=0) until 2*MIN_LEN nibbles total have been sent, then go to GAP.
REQ-025 GAP SHALL hold o_v=0 for IPG_NIBBLES i_ce cycles, then return to IDLE with an o_done pulse.
REQ-026 o_v, o_d and o_cancel SHALL change only on clocks where i_ce=1.
REQ-027 i_abort in LOAD, DATA or PAD SHALL, on the next i_ce, drive o_v=0 and o_cancel=1 for exactly one i_ce cycle, then enter GAP with the full IPG count.
REQ-028 i_abort in IDLE or GAP SHALL be ignored.
REQ-029 If i_abort and the last nibble coincide, abort SHALL take priority.
REQ-030 The nibble counter SHALL be AW+2 bits wide and SHALL never wrap for i_len <= 2^AW.
REQ-031 o_rd_addr SHALL wrap modulo 2^AW.

Reset
REQ-032 On i_reset the block SHALL go to IDLE on the next clock and clear o_v, o_d, o_cancel, o_done and o_rd_addr to 0, regardless of i_ce.
REQ-033 Reset mid-frame SHALL produce no o_cancel pulse and no o_done pulse.

Configuration
REQ-034 Padding is controlled by the macro ETHTX_PAD_EN.
REQ-035 With ETHTX_PAD_EN defined, PAD behaves as specified in REQ-024.
REQ-036 Without ETHTX_PAD_EN, the PAD state and its logic SHALL be absent, MIN_LEN SHALL be unused, and frames are sent at exactly i_len bytes.

Structure
REQ-037 State encodings and the default IPG and MIN_LEN constants SHALL reside in the shared package ethtx_pkg.
REQ-038 The block SHALL contain one sub-module, ethtx_nibbler, holding the byte register, the low/high nibble select and the nibble counter.
REQ-039 All state sequencing SHALL remain in ethtx_sequencer.

Verification
REQ-040 i_ce=1 always, buffer = 00..0F, i_cmd with len=16 -> 32 consecutive o_v nibbles 0,0,1,0,...,F,0; then 24 clocks with o_v=0; then one o_done pulse.
REQ-041 ETHTX_PAD_EN defined, len=10 -> 120 nibbles: 20 data nibbles then 100 zero nibbles; without the macro -> 20 nibbles only.
REQ-042 i_ce=1 every 4th clock, len=4 -> outputs change only on i_ce clocks; stream identical to the i_ce-always case.
REQ-043 i_abort at nibble 7 of a 64-byte frame -> next i_ce gives o_v=0 and o_cancel=1 for one i_ce; then 24-nibble gap; then o_done.
REQ-044 i_cmd with len=0 -> o_done one clock later, o_busy stays 0; i_cmd while busy -> no effect on the stream.
REQ-045 i_reset asserted mid-DATA -> next clock all outputs 0 and state IDLE, with no o_cancel and no o_done; a following i_cmd starts cleanly at address 0.
